alu_decode_reg: RTL and testbench
=================================

ALU_DECODE_REG -- requirements
Module: alu_decode_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- InstrValidD  input  1  decode-stage instruction valid
- opD  input  7  instruction opcode, bits [6:0]
- funct3D  input  3  instruction bits [14:12]
- funct7b5D  input  1  instruction bit 30
- StallE  input  1  hold the E register contents
- FlushE  input  1  load a bubble into the E register
- ALUControlE  output  3  ALU op: 0 add, 1 sub, 2 and, 3 or, 5 slt, 6 xor
- ALUSrcE  output  1  1 = immediate operand B
- RegWriteE  output  1  register-file write enable
- MemWriteE  output  1  data-memory write enable
- ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4
- BranchE  output  1  beq in execute
- JumpE  output  1  jal in execute
- ValidE  output  1  E stage holds a real instruction
- IllegalE  output  1  E stage holds an undecodable instruction
- IllegalCount  output  8  saturating count of illegal instructions

Function
REQ-002 The decode SHALL be combinational from opD/funct3D/funct7b5D; all outputs SHALL be registered, giving exactly 1 cycle of latency from D inputs to E outputs.
REQ-003 Opcode 0110011 (R-type) SHALL set RegWriteE=1 and ALUSrcE=0, with the ALU op selected by funct3D:
- 000 gives add, or sub when funct7b5D=1
- 010 gives slt
- 100 gives xor
- 110 gives or
- 111 gives and
- 001, 011, 101 are illegal
REQ-004 Opcode 0010011 (I-type ALU) SHALL use the same funct3D map as R-type with ALUSrcE=1 and RegWriteE=1. funct7b5D SHALL be ignored, so 000 always gives add.
REQ-005 Opcode 0000011 (lw) SHALL decode as: add, ALUSrcE=1, RegWriteE=1, ResultSrcE=01.
REQ-006 Opcode 0100011 (sw) SHALL decode as: add, ALUSrcE=1, MemWriteE=1.
REQ-007 Opcode 1100011 (beq) SHALL decode as: sub, BranchE=1.
REQ-008 Opcode 1101111 (jal) SHALL decode as: JumpE=1, RegWriteE=1, ResultSrcE=10, ALUControlE=0.
REQ-009 Any other opcode, or an illegal funct3D, SHALL decode as a bubble with IllegalE=1 when InstrValidD=1.
REQ-010 A bubble SHALL mean all enables and selects are 0, ALUControlE=0, and ValidE=0.
REQ-011 If InstrValidD=0, the block SHALL load a bubble with IllegalE=0.
REQ-012 Register update priority SHALL be: reset > FlushE > StallE > load.
- FlushE=1 loads a bubble with IllegalE=0, including when StallE=1 in the same cycle.
- StallE=1 with FlushE=0 holds every E output, including IllegalE.
REQ-013 IllegalCount SHALL increment by 1 only on a cycle that loads a decoded instruction with IllegalE=1 (FlushE=0, StallE=0).
REQ-014 IllegalCount SHALL saturate at 255 and never wrap.
REQ-015 Writes SHALL be safe by construction: an E-stage instruction with IllegalE=1 SHALL have RegWriteE=0, MemWriteE=0, BranchE=0 and JumpE=0.

Reset
REQ-016 Asserting reset SHALL immediately force all E outputs to bubble values (all 0) and IllegalCount to 0, independent of clk.
REQ-017 After reset deasserts, the first rising clk edge SHALL load normally. A reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- R-type funct3=000, funct7b5=1, valid -> next cycle ALUControlE=1, RegWriteE=1, ALUSrcE=0, ValidE=1.
- addi with funct7b5=1, then lw, then sw on consecutive cycles -> ALUControlE=0 each cycle; ALUSrcE=1 each cycle; ResultSrcE=00/01/00 with RegWriteE=1/1/0; MemWriteE=0/0/1.
- Opcode 1110011, valid -> IllegalE=1, all enables 0, IllegalCount 0->1; repeated 300 times -> IllegalCount=255.
- beq loaded, then StallE=1 for 3 cycles while opD changes -> BranchE=1 and ALUControlE=1 held for all 3 cycles.
- StallE=1 and FlushE=1 together with an illegal instruction -> bubble loaded, IllegalE=0, IllegalCount unchanged.
- Reset pulsed between clock edges while jal is held in E -> JumpE, RegWriteE, ResultSrcE, ValidE and IllegalCount drop to 0 immediately.

Source files
------------

// File: rtl/alu_decode_reg.sv
// Main decoder + ALU decoder feeding the D->E pipeline register, with a
// stall/flush-aware E register and a saturating illegal-instruction counter.
module alu_decode_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       InstrValidD,
    input  logic [6:0] opD,
    input  logic [2:0] funct3D,
    input  logic       funct7b5D,
    input  logic       StallE,
    input  logic       FlushE,
    output logic [2:0] ALUControlE,
    output logic       ALUSrcE,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic [1:0] ResultSrcE,
    output logic       BranchE,
    output logic       JumpE,
    output logic       ValidE,
    output logic       IllegalE,
    output logic [7:0] IllegalCount
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_XOR = 3'd6;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       alu_src;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic       jump;
        logic       valid;
        logic       illegal;
    } ctrl_t;

    ctrl_t      dec_next;
    ctrl_t      e_reg;
    logic [7:0] count_reg;

    logic [2:0] f3_alu;
    logic       f3_ok;
    logic       legal;
    ctrl_t      raw;

    // funct3 -> ALU op map shared by R-type and I-type ALU instructions
    always_comb begin
        f3_alu = ALU_ADD;
        f3_ok  = 1'b1;
        case (funct3D)
            3'b000:  f3_alu = ALU_ADD;
            3'b010:  f3_alu = ALU_SLT;
            3'b100:  f3_alu = ALU_XOR;
            3'b110:  f3_alu = ALU_OR;
            3'b111:  f3_alu = ALU_AND;
            default: f3_ok  = 1'b0;
        endcase
    end

    always_comb begin
        raw   = '0;
        legal = 1'b0;
        case (opD)
            OP_R: begin
                legal           = f3_ok;
                raw.reg_write   = 1'b1;
                raw.alu_control = (funct3D == 3'b000 && funct7b5D) ? ALU_SUB : f3_alu;
            end
            OP_I: begin
                legal           = f3_ok;
                raw.reg_write   = 1'b1;
                raw.alu_src     = 1'b1;
                raw.alu_control = f3_alu;
            end
            OP_LW: begin
                legal          = 1'b1;
                raw.alu_src    = 1'b1;
                raw.reg_write  = 1'b1;
                raw.result_src = 2'b01;
            end
            OP_SW: begin
                legal         = 1'b1;
                raw.alu_src   = 1'b1;
                raw.mem_write = 1'b1;
            end
            OP_BEQ: begin
                legal           = 1'b1;
                raw.alu_control = ALU_SUB;
                raw.branch      = 1'b1;
            end
            OP_JAL: begin
                legal          = 1'b1;
                raw.jump       = 1'b1;
                raw.reg_write  = 1'b1;
                raw.result_src = 2'b10;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal instructions become bubbles, so no side effect can escape E
    always_comb begin
        dec_next = '0;
        if (InstrValidD) begin
            if (legal) begin
                dec_next       = raw;
                dec_next.valid = 1'b1;
            end else begin
                dec_next.illegal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_reg     <= '0;
            count_reg <= 8'd0;
        end else if (FlushE) begin
            e_reg <= '0;
        end else if (!StallE) begin
            e_reg <= dec_next;
            if (dec_next.illegal && count_reg != 8'hFF)
                count_reg <= count_reg + 8'd1;
        end
    end

    assign ALUControlE  = e_reg.alu_control;
    assign ALUSrcE      = e_reg.alu_src;
    assign RegWriteE    = e_reg.reg_write;
    assign MemWriteE    = e_reg.mem_write;
    assign ResultSrcE   = e_reg.result_src;
    assign BranchE      = e_reg.branch;
    assign JumpE        = e_reg.jump;
    assign ValidE       = e_reg.valid;
    assign IllegalE     = e_reg.illegal;
    assign IllegalCount = count_reg;

endmodule

// File: tb/tb_alu_decode_reg.sv
// Self-checking bench for alu_decode_reg: vector table, directed corner
// sequences and randomized traffic checked against a behavioural model.
module tb_alu_decode_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       InstrValidD = 1'b0;
    logic [6:0] opD = 7'd0;
    logic [2:0] funct3D = 3'd0;
    logic       funct7b5D = 1'b0;
    logic       StallE = 1'b0;
    logic       FlushE = 1'b0;
    logic [2:0] ALUControlE;
    logic       ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, ValidE, IllegalE;
    logic [1:0] ResultSrcE;
    logic [7:0] IllegalCount;

    alu_decode_reg dut (
        .clk(clk), .reset(reset), .InstrValidD(InstrValidD), .opD(opD),
        .funct3D(funct3D), .funct7b5D(funct7b5D), .StallE(StallE), .FlushE(FlushE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE),
        .JumpE(JumpE), .ValidE(ValidE), .IllegalE(IllegalE), .IllegalCount(IllegalCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] alu;
        logic       src;
        logic       rw;
        logic       mw;
        logic [1:0] rs;
        logic       br;
        logic       jmp;
        logic       vld;
        logic       ill;
    } exp_t;

    typedef struct {
        logic       v;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        exp_t       exp;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t m_e = '0;
    int   m_count = 0;
    // ALU op per funct3 for the ALU-class opcodes; -1 marks an illegal funct3
    int   f3map [8] = '{0, -1, 5, -1, 6, -1, 3, 2};

    function automatic exp_t mk(int alu, int src, int rw, int mw, int rs,
                                int br, int jmp, int vld, int ill);
        exp_t e;
        e.alu = alu[2:0]; e.src = src[0]; e.rw = rw[0]; e.mw = mw[0];
        e.rs = rs[1:0]; e.br = br[0]; e.jmp = jmp[0]; e.vld = vld[0]; e.ill = ill[0];
        return e;
    endfunction

    function automatic exp_t model_decode(logic v, logic [6:0] op, logic [2:0] f3, logic f7);
        int a;
        if (!v) return '0;
        case (op)
            7'b0110011: begin
                a = f3map[f3];
                if (a < 0) return mk(0,0,0,0,0,0,0,0,1);
                if (a == 0 && f7) a = 1;
                return mk(a,0,1,0,0,0,0,1,0);
            end
            7'b0010011: begin
                a = f3map[f3];
                if (a < 0) return mk(0,0,0,0,0,0,0,0,1);
                return mk(a,1,1,0,0,0,0,1,0);
            end
            7'b0000011: return mk(0,1,1,0,1,0,0,1,0);
            7'b0100011: return mk(0,1,0,1,0,0,0,1,0);
            7'b1100011: return mk(1,0,0,0,0,1,0,1,0);
            7'b1101111: return mk(0,0,1,0,2,0,1,1,0);
            default:    return mk(0,0,0,0,0,0,0,0,1);
        endcase
    endfunction

    function automatic exp_t actual();
        return {ALUControlE, ALUSrcE, RegWriteE, MemWriteE, ResultSrcE,
                BranchE, JumpE, ValidE, IllegalE};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic drive(logic v, logic [6:0] op, logic [2:0] f3, logic f7, logic st, logic fl);
        InstrValidD = v; opD = op; funct3D = f3; funct7b5D = f7; StallE = st; FlushE = fl;
    endtask

    // One clock: advance the model from the current inputs, then compare
    task automatic cycle();
        exp_t nxt;
        int   ncnt;
        nxt  = m_e;
        ncnt = m_count;
        if (FlushE) nxt = '0;
        else if (!StallE) begin
            nxt = model_decode(InstrValidD, opD, funct3D, funct7b5D);
            if (nxt.ill && ncnt < 255) ncnt++;
        end
        @(posedge clk);
        #1;
        m_e = nxt;
        m_count = ncnt;
        cyc++;
        $display("cyc %0d v=%b op=%b f3=%b f7=%b st=%b fl=%b -> e=%h cnt=%0d",
                 cyc, InstrValidD, opD, funct3D, funct7b5D, StallE, FlushE, actual(), IllegalCount);
        chk("e_outputs", 32'(actual()), 32'(m_e));
        chk("illegal_count", 32'(IllegalCount), 32'(m_count));
    endtask

    // Asynchronous reset pulse placed between clock edges (call at edge+1)
    task automatic reset_pulse();
        #2 reset = 1'b1;
        #1;
        m_e = '0;
        m_count = 0;
        $display("reset pulse at t=%0t -> e=%h cnt=%0d", $time, actual(), IllegalCount);
        chk("async_reset_e", 32'(actual()), 32'd0);
        chk("async_reset_cnt", 32'(IllegalCount), 32'd0);
        #1 reset = 1'b0;
    endtask

    vec_t tbl [16];

    initial begin
        int cnt_before;
        logic [6:0] ops [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                7'b0100011, 7'b1100011, 7'b1101111};

        tbl[0]  = '{1, 7'b0110011, 3'b000, 0, mk(0,0,1,0,0,0,0,1,0)};
        tbl[1]  = '{1, 7'b0110011, 3'b000, 1, mk(1,0,1,0,0,0,0,1,0)};
        tbl[2]  = '{1, 7'b0110011, 3'b010, 0, mk(5,0,1,0,0,0,0,1,0)};
        tbl[3]  = '{1, 7'b0110011, 3'b100, 1, mk(6,0,1,0,0,0,0,1,0)};
        tbl[4]  = '{1, 7'b0110011, 3'b110, 0, mk(3,0,1,0,0,0,0,1,0)};
        tbl[5]  = '{1, 7'b0110011, 3'b111, 0, mk(2,0,1,0,0,0,0,1,0)};
        tbl[6]  = '{1, 7'b0110011, 3'b001, 0, mk(0,0,0,0,0,0,0,0,1)};
        tbl[7]  = '{1, 7'b0010011, 3'b000, 1, mk(0,1,1,0,0,0,0,1,0)};
        tbl[8]  = '{1, 7'b0000011, 3'b010, 0, mk(0,1,1,0,1,0,0,1,0)};
        tbl[9]  = '{1, 7'b0100011, 3'b010, 0, mk(0,1,0,1,0,0,0,1,0)};
        tbl[10] = '{1, 7'b1100011, 3'b000, 0, mk(1,0,0,0,0,1,0,1,0)};
        tbl[11] = '{1, 7'b1101111, 3'b000, 0, mk(0,0,1,0,2,0,1,1,0)};
        tbl[12] = '{1, 7'b1110011, 3'b000, 0, mk(0,0,0,0,0,0,0,0,1)};
        tbl[13] = '{0, 7'b0110011, 3'b000, 0, mk(0,0,0,0,0,0,0,0,0)};
        tbl[14] = '{1, 7'b0010011, 3'b111, 1, mk(2,1,1,0,0,0,0,1,0)};
        tbl[15] = '{1, 7'b0010011, 3'b101, 0, mk(0,0,0,0,0,0,0,0,1)};

        // Reset state, then release and check the first edge loads normally
        @(posedge clk);
        #1;
        chk("reset_e", 32'(actual()), 32'd0);
        chk("reset_cnt", 32'(IllegalCount), 32'd0);
        reset = 1'b0;

        // Illegal opcode: count 0 -> 1, then saturates at 255 after 300
        drive(1, 7'b1110011, 3'b000, 0, 0, 0);
        cycle();
        chk("illegal_first_cnt", 32'(IllegalCount), 32'd1);
        chk("illegal_bubble", 32'({RegWriteE, MemWriteE, BranchE, JumpE, ValidE, IllegalE}), 32'b000001);
        for (int i = 1; i < 300; i++) cycle();
        chk("illegal_saturate", 32'(IllegalCount), 32'd255);

        reset_pulse();

        // Vector table
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].f3, tbl[i].f7, 0, 0);
            cycle();
            chk($sformatf("table_%0d", i), 32'(actual()), 32'(tbl[i].exp));
        end

        // beq held through a 3-cycle stall while D changes
        drive(1, 7'b1100011, 3'b000, 0, 0, 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 7'($urandom), 3'($urandom), 1'($urandom), 1, 0);
            cycle();
            chk("stall_hold_beq", 32'({BranchE, ALUControlE}), 32'b1001);
        end

        // Stall and flush together with an illegal instruction
        cnt_before = m_count;
        drive(1, 7'b1111111, 3'b000, 0, 1, 1);
        cycle();
        chk("flush_stall_illegal", 32'({ValidE, IllegalE}), 32'd0);
        chk("flush_stall_cnt", 32'(IllegalCount), 32'(cnt_before));

        // jal held by a stall, then an asynchronous reset discards it
        drive(1, 7'b1101111, 3'b000, 0, 0, 0);
        cycle();
        chk("jal_loaded", 32'({JumpE, RegWriteE, ResultSrcE, ValidE}), 32'b11101);
        drive(1, 7'b0110011, 3'b000, 0, 1, 0);
        cycle();
        reset_pulse();
        chk("jal_reset", 32'({JumpE, RegWriteE, ResultSrcE, ValidE}), 32'd0);
        drive(1, 7'b0000011, 3'b010, 0, 0, 0);
        cycle();
        chk("post_reset_load", 32'({ValidE, ResultSrcE}), 32'b101);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int k;
            logic [6:0] op;
            k  = $urandom_range(0, 6);
            op = (k == 6) ? 7'($urandom) : ops[k];
            drive(($urandom_range(0, 9) != 0), op, 3'($urandom), 1'($urandom),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
